// File: rtl/argmin_seq_ctrl.sv
// Sequential arg-min controller: streams up to 8 candidates through one
// shared comparator and returns the smallest value with its arrival index.

// Two-input min selector carrying ids; picks data1 only when strictly smaller
// so that on a tie the running best (earlier arrival) is kept.
module cmp_with_id #(
  parameter int W = 14
) (
  input  logic [W-1:0] i_data1,
  input  logic [2:0]   i_id1,
  input  logic [W-1:0] i_data2,
  input  logic [2:0]   i_id2,
  output logic [W-1:0] o_small_data,
  output logic [2:0]   o_small_id
);
  logic w_take1;

  assign w_take1      = (i_data1 < i_data2);
  assign o_small_data = w_take1 ? i_data1 : i_data2;
  assign o_small_id   = w_take1 ? i_id1   : i_id2;
endmodule

module argmin_seq_ctrl #(
  parameter int ADDW = 14
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_num,
  input  logic            i_in_valid,
  input  logic [ADDW-1:0] i_in_data,
  output logic            o_in_ready,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [ADDW-1:0] o_out_data,
  output logic [2:0]      o_out_id,
  output logic            o_busy
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  logic [1:0]      r_state;
  logic [2:0]      r_idx;
  logic [2:0]      r_last_idx;
  logic [ADDW-1:0] r_best_data;
  logic [2:0]      r_best_id;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [ADDW-1:0] r_out_data;
  logic [2:0]      r_out_id;

  logic [1:0]      w_next_state;
  logic [2:0]      w_next_idx;
  logic [2:0]      w_next_last_idx;
  logic [ADDW-1:0] w_next_best_data;
  logic [2:0]      w_next_best_id;
  logic            w_accept;
  logic [ADDW-1:0] w_small_data;
  logic [2:0]      w_small_id;

  // in_ready is a registered copy of "state is FIRST or SCAN"
  assign w_accept = i_in_valid & r_in_ready;

  cmp_with_id #(.W(ADDW)) u_cmp (
    .i_data1      (i_in_data),
    .i_id1        (r_idx),
    .i_data2      (r_best_data),
    .i_id2        (r_best_id),
    .o_small_data (w_small_data),
    .o_small_id   (w_small_id)
  );

  // Next-state and datapath update decode for the search FSM
  always_comb begin
    w_next_state     = r_state;
    w_next_idx       = r_idx;
    w_next_last_idx  = r_last_idx;
    w_next_best_data = r_best_data;
    w_next_best_id   = r_best_id;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_last_idx = i_num;
          w_next_idx      = 3'd0;
          w_next_state    = ST_FIRST;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FIRST: begin
        // First beat seeds the running best directly; comparator bypassed
        if (w_accept) begin
          w_next_best_data = i_in_data;
          w_next_best_id   = 3'd0;
          if (r_last_idx == 3'd0) begin
            w_next_state = ST_RESULT;
          end else begin
            w_next_idx   = 3'd1;
            w_next_state = ST_SCAN;
          end
        end else begin
          w_next_state = ST_FIRST;
        end
      end
      ST_SCAN: begin
        if (w_accept) begin
          w_next_best_data = w_small_data;
          w_next_best_id   = w_small_id;
          if (r_idx == r_last_idx) begin
            w_next_state = ST_RESULT;
          end else begin
            w_next_idx   = r_idx + 3'd1;
            w_next_state = ST_SCAN;
          end
        end else begin
          w_next_state = ST_SCAN;
        end
      end
      ST_RESULT: begin
        // start is deliberately not looked at here, even during the handshake
        if (i_out_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESULT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state, beat counter and running-best registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_last_idx  <= 3'd0;
      r_best_data <= {ADDW{1'b0}};
      r_best_id   <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_idx       <= w_next_idx;
      r_last_idx  <= w_next_last_idx;
      r_best_data <= w_next_best_data;
      r_best_id   <= w_next_best_id;
    end
  end

  // Registered outputs decoded from the next state; result captured on entry
  // to RESULT and then held until the following search completes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= {ADDW{1'b0}};
      r_out_id    <= 3'd0;
    end else begin
      r_in_ready  <= (w_next_state == ST_FIRST) || (w_next_state == ST_SCAN);
      r_out_valid <= (w_next_state == ST_RESULT);
      r_busy      <= (w_next_state != ST_IDLE);
      if ((w_next_state == ST_RESULT) && (r_state != ST_RESULT)) begin
        r_out_data <= w_next_best_data;
        r_out_id   <= w_next_best_id;
      end else begin
        r_out_data <= r_out_data;
        r_out_id   <= r_out_id;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_out_data  = r_out_data;
  assign o_out_id    = r_out_id;
endmodule

// File: tb/tb_argmin_seq_ctrl.sv
// Self-checking bench for argmin_seq_ctrl: scoreboard of expected
// {min, id} pushed at stimulus time, popped on each result handshake.
module tb_argmin_seq_ctrl;
  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  num;
  logic        in_valid;
  logic [13:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_data;
  logic [2:0]  out_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_results = 0;
  logic [16:0] exp_q[$];
  logic [13:0] beats [8];

  argmin_seq_ctrl #(.ADDW(14)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_num       (num),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_id    (out_id),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: check each accepted result against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_results++;
      if (exp_q.size() == 0) begin
        chk_val("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk_val("sb_data", {18'd0, out_data}, {18'd0, e[16:3]});
        chk_val("sb_id", {29'd0, out_id}, {29'd0, e[2:0]});
      end
    end
  end

  // Drive one search of n beats from beats[]; optional stall before beat index
  // stall_at. Leaves the bench in the first RESULT cycle.
  task automatic do_search(input int n, input int stall_at, input int stall_len);
    logic [13:0] m;
    logic [2:0]  mi;
    m  = beats[0];
    mi = 3'd0;
    for (int i = 1; i < n; i++) begin
      if (beats[i] < m) begin
        m  = beats[i];
        mi = 3'(i);
      end
    end
    exp_q.push_back({m, mi});
    start = 1'b1;
    num   = 3'(n - 1);
    tick();
    start = 1'b0;
    chk_val("busy_rise", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk_val("stall_no_result", {31'd0, out_valid}, 32'd0);
        end
      end
      in_valid = 1'b1;
      in_data  = beats[i];
      chk_val("in_ready_beat", {31'd0, in_ready}, 32'd1);
      chk_val("no_early_result", {31'd0, out_valid}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_data  = 14'd0;
    chk_val("out_valid_rise", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num = 3'd0; in_valid = 1'b0;
    in_data = 14'd0; out_ready = 1'b1;
    repeat (3) tick();
    chk_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_val("rst_busy", {31'd0, busy}, 32'd0);
    chk_val("rst_out_data", {18'd0, out_data}, 32'd0);
    chk_val("rst_out_id", {29'd0, out_id}, 32'd0);
    rst = 1'b0;
    tick();

    // Full 8-candidate search at full rate
    beats = '{14'd500, 14'd300, 14'd9000, 14'd120, 14'd16383, 14'd121, 14'd4000, 14'd130};
    do_search(8, -1, 0);
    chk_val("full_data", {18'd0, out_data}, 32'd120);
    chk_val("full_id", {29'd0, out_id}, 32'd3);
    tick();
    chk_val("full_ov_one_cycle", {31'd0, out_valid}, 32'd0);
    chk_val("full_busy_fall", {31'd0, busy}, 32'd0);

    // Single candidate
    beats = '{14'd77, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
    do_search(1, -1, 0);
    tick();
    chk_val("single_ov_drop", {31'd0, out_valid}, 32'd0);

    // Ties keep the earliest index; extremes
    beats = '{14'd50, 14'd50, 14'd50, 14'd50, 14'd0, 14'd0, 14'd0, 14'd0};
    do_search(4, -1, 0);
    chk_val("tie_id", {29'd0, out_id}, 32'd0);
    tick();
    beats = '{14'd16383, 14'd16383, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
    do_search(3, -1, 0);
    chk_val("ext_data", {18'd0, out_data}, 32'd0);
    chk_val("ext_id", {29'd0, out_id}, 32'd2);
    tick();

    // Input stall and result back-pressure, start during RESULT ignored
    out_ready = 1'b0;
    beats = '{14'd40, 14'd30, 14'd20, 14'd10, 14'd5, 14'd0, 14'd0, 14'd0};
    do_search(5, 2, 3);
    for (int k = 0; k < 4; k++) begin
      chk_val("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk_val("bp_hold_data", {18'd0, out_data}, 32'd5);
      chk_val("bp_hold_id", {29'd0, out_id}, 32'd4);
      start = (k == 2) ? 1'b1 : 1'b0;
      tick();
    end
    chk_val("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_val("bp_ov_drop", {31'd0, out_valid}, 32'd0);
    chk_val("bp_busy_fall", {31'd0, busy}, 32'd0);
    tick();
    chk_val("bp_no_new_search", {31'd0, busy}, 32'd0);
    chk_val("bp_no_in_ready", {31'd0, in_ready}, 32'd0);
    chk_val("bp_result_hold", {18'd0, out_data}, 32'd5);

    // Reset mid-search: discard, outputs clear without a clock edge
    start = 1'b1;
    num   = 3'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 14'(100 + i);
      tick();
    end
    rst = 1'b1;
    #1;
    chk_val("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk_val("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_val("mrst_busy", {31'd0, busy}, 32'd0);
    chk_val("mrst_out_data", {18'd0, out_data}, 32'd0);
    chk_val("mrst_out_id", {29'd0, out_id}, 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    beats = '{14'd9, 14'd8, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
    do_search(2, -1, 0);
    chk_val("post_rst_data", {18'd0, out_data}, 32'd8);
    chk_val("post_rst_id", {29'd0, out_id}, 32'd1);
    tick();

    // Extra beats beyond num+1 are never consumed
    exp_q.push_back({14'd2, 3'd1});
    start = 1'b1;
    num   = 3'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 14'd6;
    tick();
    chk_val("prev_result_hold_data", {18'd0, out_data}, 32'd8);
    chk_val("prev_result_hold_id", {29'd0, out_id}, 32'd1);
    in_data = 14'd2;
    tick();
    chk_val("xb_out_valid", {31'd0, out_valid}, 32'd1);
    in_data = 14'd1;
    chk_val("xb_ready_beat3", {31'd0, in_ready}, 32'd0);
    tick();
    in_data = 14'd0;
    chk_val("xb_ready_beat4", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk_val("xb_final_data", {18'd0, out_data}, 32'd2);
    repeat (2) tick();

    chk_val("result_count", n_results, 32'd7);
    chk_val("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
